lif_neuron_array: RTL

//  Parametrised successor to the single 8-bit LIF neuron: NUM_NEURONS independent leaky

---
 rtl/lif_neuron_array.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons stepped together by step_en, with run-time
// threshold, shift leak and refractory period. Define SPIKE_COUNT_EN for per-channel spike counters.
module lif_neuron_array #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IW          = 8,
    parameter int unsigned VW          = 12,
    parameter int unsigned RW          = 4
`ifdef SPIKE_COUNT_EN
    ,
    parameter int unsigned CW          = 8
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        step_en,
    input  logic [NUM_NEURONS*IW-1:0]   input_current,
    input  logic [VW-1:0]               threshold,
    input  logic [4:0]                  leak_shift,
    input  logic [RW-1:0]               refrac_cycles,
    output logic [NUM_NEURONS-1:0]      spike,
    output logic                        spike_any,
    output logic [NUM_NEURONS*VW-1:0]   v_mem
`ifdef SPIKE_COUNT_EN
    ,
    output logic [NUM_NEURONS*CW-1:0]   spike_count
`endif
);

    logic [VW-1:0]          v_q     [NUM_NEURONS];
    logic [VW-1:0]          v_d     [NUM_NEURONS];
    logic [RW-1:0]          rc_q    [NUM_NEURONS];
    logic [RW-1:0]          rc_d    [NUM_NEURONS];
    logic [VW:0]            v_sum   [NUM_NEURONS];
    logic [VW-1:0]          v_sat   [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spike_q;
    logic [NUM_NEURONS-1:0] spike_d;
    logic                   spike_any_q;
    logic                   spike_any_d;
`ifdef SPIKE_COUNT_EN
    logic [CW-1:0]          cnt_q   [NUM_NEURONS];
    logic [CW-1:0]          cnt_d   [NUM_NEURONS];
`endif

    // Per-channel step: leak, integrate with saturation, fire or serve refractory time
    always_comb begin
        spike_d = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            v_d[i]  = v_q[i];
            rc_d[i] = rc_q[i];
            // v - (v >> s) never underflows, so VW+1 bits hold the sum with headroom
            v_sum[i] = (VW+1)'(v_q[i]) - (VW+1)'(v_q[i] >> leak_shift)
                     + (VW+1)'(input_current[i*IW +: IW]);
            v_sat[i] = v_sum[i][VW] ? {VW{1'b1}} : v_sum[i][VW-1:0];
            if (step_en) begin
                if (rc_q[i] != '0) begin
                    rc_d[i] = rc_q[i] - RW'(1);
                    v_d[i]  = '0;
                end else if (v_sat[i] >= threshold) begin
                    spike_d[i] = 1'b1;
                    v_d[i]     = '0;
                    rc_d[i]    = refrac_cycles;
                end else begin
                    v_d[i] = v_sat[i];
                end
            end
        end
        spike_any_d = |spike_d;
    end

`ifdef SPIKE_COUNT_EN
    // Saturating spike counters, cleared only by reset
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (spike_d[i] && (cnt_q[i] != {CW{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q     <= '0;
            spike_any_q <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]  <= '0;
                rc_q[i] <= '0;
            end
        end else begin
            spike_q     <= spike_d;
            spike_any_q <= spike_any_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]  <= v_d[i];
                rc_q[i] <= rc_d[i];
            end
        end
    end

    assign spike     = spike_q;
    assign spike_any = spike_any_q;

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_out
        assign v_mem[gi*VW +: VW] = v_q[gi];
`ifdef SPIKE_COUNT_EN
        assign spike_count[gi*CW +: CW] = cnt_q[gi];
`endif
    end

endmodule
